// File: rtl/shiftsub.sv
// rtl/shiftsub.sv - sequential signed restoring divider, 2*WIDTH / WIDTH -> WIDTH quotient and remainder
`timescale 1ns/1ps
module shiftsub #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic                 div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t            state;
  logic [WIDTH-1:0]  rem;
  logic [WIDTH-1:0]  dvd;
  logic [WIDTH-1:0]  dvs;
  logic [CW-1:0]     cnt;
  logic              sign_q;
  logic              sign_r;
  logic              early_ovf;
  logic              dz;

  logic [2*WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0]   divisor_mag;
  logic [WIDTH:0]     shift_val;
  logic [WIDTH:0]     diff;
  logic               take;
  logic               range_ovf;
  logic               any_ovf;
  logic               sat_neg;

  // Unary minus on the full width keeps the most-negative operands as exact unsigned magnitudes.
  assign dividend_mag = dividend[2*WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[WIDTH-1]    ? -divisor  : divisor;

  // The partial remainder stays below the divisor, so only WIDTH bits need storing;
  // the trial compare/subtract is done WIDTH+1 bits wide.
  assign shift_val = {rem, dvd[WIDTH-1]};
  assign diff      = shift_val - {1'b0, dvs};
  assign take      = shift_val >= {1'b0, dvs};

  assign range_ovf = sign_q ? (dvd[WIDTH-1] & (|dvd[WIDTH-2:0])) : dvd[WIDTH-1];
  assign any_ovf   = dz | early_ovf | range_ovf;
  assign sat_neg   = dz ? sign_r : sign_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rem       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      early_ovf <= 1'b0;
      dz        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem       <= dividend_mag[2*WIDTH-1:WIDTH];
            dvd       <= dividend_mag[WIDTH-1:0];
            dvs       <= divisor_mag;
            sign_q    <= dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
            sign_r    <= dividend[2*WIDTH-1];
            early_ovf <= dividend_mag[2*WIDTH-1:WIDTH] >= divisor_mag;
            dz        <= (divisor == '0);
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          rem <= take ? diff[WIDTH-1:0] : shift_val[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], take};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= SIGN;
        end
        SIGN: begin
          quotient  <= any_ovf ? (sat_neg ? Q_MIN : Q_MAX) : (sign_q ? -dvd : dvd);
          remainder <= any_ovf ? '0 : (sign_r ? -rem : rem);
          ovf       <= any_ovf;
          div_zero  <= dz;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shiftsub.sv
// tb/tb_shiftsub.sv - randomized self-checking bench for shiftsub against an integer-division model
`timescale 1ns/1ps
module tb_shiftsub;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        div_zero;

  int n_tests = 0;
  int n_fail  = 0;

  shiftsub #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .ovf(ovf), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact signed division on 64-bit integers, then the saturation rules.
  function automatic void ref_div(input logic [31:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic o, output logic z);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z = (sb == 0);
    o = 1'b0;
    if (z) begin
      o = 1'b1;
      q = (sa >= 0) ? 16'h7FFF : 16'h8000;
      r = 16'h0000;
    end else begin
      lq = sa / sb;
      lr = sa % sb;
      if (lq > 32767 || lq < -32768) begin
        o = 1'b1;
        q = (lq > 0) ? 16'h7FFF : 16'h8000;
        r = 16'h0000;
      end else begin
        q = lq[15:0];
        r = lr[15:0];
      end
    end
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r,
                        output logic o, output logic z, output int lat, output logic bsy0);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    bsy0     = busy;
    dividend = $urandom;
    divisor  = 16'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q = quotient;
    r = remainder;
    o = ovf;
    z = div_zero;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    dividend = 32'h1234_5678;
    divisor = 16'h0042;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({quotient, remainder, busy, done, ovf, div_zero} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b ovf=%b dz=%b, need all zero",
               quotient, remainder, busy, done, ovf, div_zero);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    int ta[13] = '{1000, -1000, 1000, -1000, 1234, -5, 32768, -32768, 32'h8000_0000,
                   32767, -32769, 0, 32'h7FFF_FFFF};
    int tb[13] = '{7, 7, -7, -7, 0, 0, 1, 1, -1, 1, 1, 5, -32768};
    int tq[13] = '{142, -142, -142, 142, 32767, -32768, 32767, -32768, 32767,
                   32767, -32768, 0, -32768};
    int tr[13] = '{6, -6, 6, -6, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic to[13] = '{0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 1, 0, 1};
    logic tz[13] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    logic [15:0] q, r, eq, er;
    logic o, z, b0;
    int lat;
    for (int i = 0; i < 13; i++) begin
      run_op(ta[i], 16'(tb[i]), q, r, o, z, lat, b0);
      eq = 16'(tq[i]);
      er = 16'(tr[i]);
      n_tests++;
      if (lat !== 17 || b0 !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_timing[%0d]: latency=%0d busy_after_start=%b, need 17 and 1", i, lat, b0);
      end
      n_tests++;
      if (q !== eq || r !== er || o !== to[i] || z !== tz[i]) begin
        n_fail++;
        $display("FAIL directed_result[%0d] %0d/%0d: got q=%h r=%h ovf=%b dz=%b, need q=%h r=%h ovf=%b dz=%b",
                 i, ta[i], tb[i], q, r, o, z, eq, er, to[i], tz[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [15:0] b, q, r, eq, er;
    logic o, z, eo, ez, b0;
    int lat;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0: begin a = $urandom; b = 16'($urandom); end
        1: begin
             b = 16'($urandom);
             a = 32'($signed(16'($urandom)) * $signed(b)) + 32'($urandom_range(0, 200));
           end
        default: begin a = $urandom >> $urandom_range(0, 31); b = 16'($urandom_range(0, 40)); end
      endcase
      if ($urandom_range(0, 1) == 1) a = -a;
      ref_div(a, b, eq, er, eo, ez);
      run_op(a, b, q, r, o, z, lat, b0);
      n_tests++;
      if (lat !== 17 || q !== eq || r !== er || o !== eo || z !== ez) begin
        n_fail++;
        $display("FAIL random[%0d] %h/%h: got q=%h r=%h ovf=%b dz=%b lat=%0d, need q=%h r=%h ovf=%b dz=%b lat=17",
                 i, a, b, q, r, o, z, lat, eq, er, eo, ez);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int lat;
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 5) begin
        dividend = 32'd50;
        divisor  = 16'd5;
        start    = 1'b1;
      end
      if (lat == 6) start = 1'b0;
    end
    n_tests++;
    if (lat !== 17 || quotient !== 16'd142 || remainder !== 16'd6 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL start_while_busy: got q=%h r=%h ovf=%b lat=%0d, need q=008e r=0006 ovf=0 lat=17",
               quotient, remainder, ovf, lat);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_single_cycle: got done=%b busy=%b one cycle after done, need 0 0", done, busy);
    end
  endtask

  task automatic test_mid_reset;
    logic [15:0] q, r;
    logic o, z, b0;
    int lat, dones;
    run_op(-32'sd1000, 16'd7, q, r, o, z, lat, b0);
    @(negedge clk);
    dividend = 32'd999;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({quotient, remainder, busy, done, ovf, div_zero} !== 36'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got q=%h r=%h busy=%b done=%b ovf=%b dz=%b, need all zero",
               quotient, remainder, busy, done, ovf, div_zero);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    n_tests++;
    if (dones !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: got %0d done pulses busy=%b after reset, need 0 and 0", dones, busy);
    end
    run_op(32'd1000, 16'd7, q, r, o, z, lat, b0);
    n_tests++;
    if (lat !== 17 || q !== 16'd142 || r !== 16'd6 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_op: got q=%h r=%h ovf=%b lat=%0d, need q=008e r=0006 ovf=0 lat=17",
               q, r, o, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a, b, na, nb;
    int lat;
    a = 16'($urandom);
    do b = 16'($urandom); while (b == 16'h0 || (a == 16'h8000 && b == 16'hFFFF));
    @(negedge clk);
    dividend = 32'($signed(a) * $signed(b));
    divisor  = b;
    start    = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = $urandom;
      lat = 0;
      while (!done && lat < 40) begin
        @(posedge clk);
        #1;
        lat++;
      end
      n_tests++;
      if (lat !== 17 || quotient !== a || remainder !== 16'h0 || ovf !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL round_trip[%0d] (%0d*%0d)/%0d: got q=%h r=%h ovf=%b busy=%b lat=%0d, need q=%h r=0000 ovf=0 busy=0 lat=17",
                 i, $signed(a), $signed(b), $signed(b), quotient, remainder, ovf, busy, lat, a);
      end
      if (i < 999) begin
        na = 16'($urandom);
        do nb = 16'($urandom); while (nb == 16'h0 || (na == 16'h8000 && nb == 16'hFFFF));
        a = na;
        b = nb;
        dividend = 32'($signed(a) * $signed(b));
        divisor  = b;
        start    = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
